// File: rtl/decoder_line_encoder.sv
// Re-encodes a 4-bit active-low decoder line vector into {A,B}, EN and an illegal-pattern flag,
// holding the result in a one-entry valid/ready stage with a saturating illegal-pattern counter.
//
// state | meaning
// EMPTY | no result held, out_valid=0, stage always ready
// FULL  | result held in A/B/EN/err, out_valid=1, ready only when downstream takes it
module decoder_line_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       y_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             A,
    output logic             B,
    output logic             EN,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [3:0]       lines;
    logic [3:0]       lines_less_one;
    logic             enc_any, enc_multi;
    logic [1:0]       enc_sel;
    logic             enc_en, enc_err;
    logic             accept;
    logic [CNT_W-1:0] cnt_base, cnt_d;
    logic             sticky_d;

    assign lines          = ~y_n;
    assign lines_less_one = lines - 4'd1;
    assign enc_any        = |lines;
    // x & (x-1) is non-zero exactly when more than one bit is set
    assign enc_multi      = |(lines & lines_less_one);
    assign enc_en         = enc_any & ~enc_multi;
    assign enc_err        = enc_multi;

    always_comb begin
        enc_sel = 2'd0;
        if (lines[0])      enc_sel = 2'd0;
        else if (lines[1]) enc_sel = 2'd1;
        else if (lines[2]) enc_sel = 2'd2;
        else if (lines[3]) enc_sel = 2'd3;
    end

    assign out_valid = (state_q == FULL);
    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // clear is applied before the increment so a same-cycle illegal accept counts as 1
    always_comb begin
        cnt_base = clr_err ? '0 : err_count;
        cnt_d    = cnt_base;
        if (accept && enc_err && (cnt_base != CNT_MAX))
            cnt_d = cnt_base + CNT_W'(1);
        sticky_d = (err_sticky & ~clr_err) | (accept & enc_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            A          <= 1'b0;
            B          <= 1'b0;
            EN         <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_count  <= cnt_d;
            err_sticky <= sticky_d;
            if (accept) begin
                A   <= enc_sel[1];
                B   <= enc_sel[0];
                EN  <= enc_en;
                err <= enc_err;
            end
        end
    end

endmodule

// File: tb/tb_decoder_line_encoder.sv
// Bench for decoder_line_encoder: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the decoder run in reverse.
module tb_decoder_line_encoder;

    localparam int CNT_W   = 2;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       y_n;
    logic             in_valid;
    logic             in_ready;
    logic             A, B, EN, err;
    logic             out_valid;
    logic             out_ready;
    logic             clr_err;
    logic [CNT_W-1:0] err_count;
    logic             err_sticky;

    always #5 clk = ~clk;

    decoder_line_encoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .y_n        (y_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .EN         (EN),
        .err        (err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clr_err    (clr_err),
        .err_count  (err_count),
        .err_sticky (err_sticky)
    );

    int n_vec  = 0;
    int n_miss = 0;

    bit   m_known = 1'b0;
    bit   m_valid, m_a, m_b, m_en, m_err, m_sticky;
    int   m_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Decoder in reverse: find which lines are low and what a 2-to-4 decoder would have needed.
    function automatic void ref_encode(input logic [3:0] y, output bit a, output bit b,
                                       output bit en, output bit er);
        int lows;
        int first;
        lows  = 0;
        first = 0;
        for (int i = 3; i >= 0; i--) begin
            if (y[i] == 1'b0) begin
                lows++;
                first = i;
            end
        end
        en = (lows == 1);
        er = (lows >= 2);
        a  = (first / 2) == 1;
        b  = (first % 2) == 1;
    endfunction

    task automatic step(input logic r, input logic [3:0] y, input logic iv,
                        input logic orr, input logic ce);
        bit acc, ea, eb, een, eer;
        @(negedge clk);
        rst = r; y_n = y; in_valid = iv; out_ready = orr; clr_err = ce;
        #1;
        if (m_known) begin
            check("out_valid",  out_valid,  m_valid);
            check("in_ready",   in_ready,   !m_valid || orr);
            check("A",          A,          m_a);
            check("B",          B,          m_b);
            check("EN",         EN,         m_en);
            check("err",        err,        m_err);
            check("err_count",  err_count,  m_cnt);
            check("err_sticky", err_sticky, m_sticky);
        end
        @(posedge clk);
        if (r) begin
            m_known = 1'b1;
            m_valid = 0; m_a = 0; m_b = 0; m_en = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
        end else begin
            acc = iv && (!m_valid || orr);
            ref_encode(y, ea, eb, een, eer);
            if (ce) begin
                m_cnt    = 0;
                m_sticky = 0;
            end
            if (acc) begin
                m_valid = 1; m_a = ea; m_b = eb; m_en = een; m_err = eer;
                if (eer) begin
                    m_sticky = 1;
                    if (m_cnt < CNT_TOP) m_cnt++;
                end
            end else if (orr) begin
                m_valid = 0;
            end
        end
    endtask

    logic [3:0] legal_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111};
    logic [3:0] bad_seq   [5] = '{4'b0101, 4'b0011, 4'b0000, 4'b1001, 4'b1100};

    initial begin
        rst = 1'b1; y_n = 4'b1111; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;

        // reset held with in_valid asserted
        step(1, 4'b1110, 1, 1, 0);
        step(1, 4'b1110, 1, 1, 0);
        step(0, 4'b1111, 0, 1, 0);

        // legal sweep back-to-back, then drain
        foreach (legal_seq[i]) step(0, legal_seq[i], 1, 1, 0);
        step(0, 4'b1111, 0, 1, 0);
        step(0, 4'b1111, 0, 1, 0);

        // backpressure on a loaded 1011
        step(0, 4'b1011, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 4'b0000, 1, 0, 0);
        step(0, 4'b1110, 0, 1, 0);
        step(0, 4'b1111, 0, 1, 0);

        // illegal pattern, then clear coinciding with another illegal accept
        step(0, 4'b0101, 1, 1, 0);
        step(0, 4'b0011, 1, 1, 1);
        step(0, 4'b1111, 0, 1, 0);
        #2;
        check("clr_with_illegal", err_count, 1);

        // saturation
        step(0, 4'b1111, 0, 1, 1);
        foreach (bad_seq[i]) step(0, bad_seq[i], 1, 1, 0);
        step(0, 4'b1111, 0, 1, 0);
        #2;
        check("saturated", err_count, CNT_TOP);

        // reset while FULL and stalled
        step(0, 4'b0110, 1, 0, 0);
        step(0, 4'b1111, 0, 0, 0);
        step(1, 4'b1111, 1, 0, 0);
        step(0, 4'b1111, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 79) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 11) == 0));
        end
        step(0, 4'b1111, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
